vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the pixel generator: samples hs, vs and 12-bit RGB on the pixel clock.
- Recovers line length and frame height, and regenerates x/y pixel coordinates with a pixel-valid strobe.
- Declares lock when timing matches the configured mode, and produces a per-frame 16-bit checksum of active pixels.
- Used in loopback/self-check builds and in the testbench to verify the generator.

Parameters:
- H_TOTAL, 1056, expected pclk cycles per line (800x600@60).
- V_TOTAL, 628, expected lines per frame.
- H_ACTIVE, 800, active pixels per line.
- V_ACTIVE, 600, active lines per frame.
- H_SYNC_TO_ACT, 216, cycles from hs leading edge to first active pixel (sync 128 + back porch 88).
- V_SYNC_TO_ACT, 27, lines from vs-aligned line 0 to first active line (sync 4 + back porch 23).
- HS_POL, 1, asserted level of hs.
- VS_POL, 1, asserted level of vs.
- LOCK_FRAMES, 2, consecutive good frames required for lock.

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- hs  in  1  horizontal sync
- vs  in  1  vertical sync
- r  in  4  red
- g  in  4  green
- b  in  4  blue
- pix_valid  out  1  x/y/pix describe an active pixel
- x  out  11  recovered column, 0..H_ACTIVE-1
- y  out  11  recovered row, 0..V_ACTIVE-1
- pix  out  12  {r,g,b} of that pixel
- h_total  out  11  last measured line length
- v_total  out  11  last measured frame height
- locked  out  1  timing matches mode
- frame_done  out  1  one-cycle pulse at each vs leading edge
- frame_sum  out  16  checksum of the frame just ended
- sync_err  out  1  one-cycle pulse on a bad line while locked

Behaviour:
- Reset: already decided, one clock (pclk); reset rst is synchronous and active-high. On rst all outputs go to 0, all counters and the good-frame count clear, and frame_seen clears.
- Stage 1: register hs, vs and rgb. A leading edge is (sync_q == POL) && (sync_q2 != POL).
- hcnt (11 bit): 0 on the hs leading-edge sample, otherwise +1. Saturates at 2047 with no wrap.
- At each hs leading edge:
  - h_total <= hcnt + 1 of the ending line.
  - If that length != H_TOTAL: set the frame-bad flag. If locked, pulse sync_err and clear locked on the next cycle.
  - Saturated hcnt counts as a bad line.
- vs leading edge sets vs_pend. At the next hs leading edge, lcnt <= 0 and vs_pend clears; otherwise each hs leading edge does lcnt+1. lcnt saturates at 2047.
- Frame bookkeeping on the vs leading edge:
  - frame_done pulses and v_total <= lcnt + 1.
  - frame_sum <= accumulator, then the accumulator clears.
  - Good frame: v_total == V_TOTAL and frame-bad clear. Good increments good_cnt (saturating); bad clears it.
  - locked = frame_seen && good_cnt >= LOCK_FRAMES.
  - frame-bad clears.
  - The first vs edge after reset only sets frame_seen; that frame is not judged.
- Active window: frame_seen, hcnt in [H_SYNC_TO_ACT, H_SYNC_TO_ACT+H_ACTIVE), lcnt in [V_SYNC_TO_ACT, V_SYNC_TO_ACT+V_ACTIVE).
  - x = hcnt - H_SYNC_TO_ACT; y = lcnt - V_SYNC_TO_ACT.
  - pix_valid does not depend on locked.
- Latency: a sample on input edge N appears on pix_valid/x/y/pix at edge N+2. All outputs are registered.
- Checksum: 16-bit modulo-2^16 sum of zero-extended pix over all pix_valid cycles.
- Simultaneous hs and vs leading edges: vs_pend is taken by that same hs edge, so lcnt <= 0.
- Sync-polarity glitches shorter than 1 cycle are not filtered.

Test Plan:
- 3 nominal 800x600 frames, uniform 12'h888 -> h_total=1056, v_total=628; locked rises after the 3rd vs edge; frame_sum=16'h1800; 480000 pix_valid cycles per frame.
- Single white pixel at generator (x=401,y=300), rest 0 -> exactly one pix_valid with pix=12'hFFF, x=401, y=300; frame_sum=16'h0FFF.
- Locked, then one line shortened to 1055 -> sync_err one pulse; locked=0 next cycle; h_total=1055; locked returns 2 good frames later.
- hs held deasserted for 3000 cycles -> hcnt saturates; pix_valid stays low once the window passes; locked drops at the resumed hs edge; no wrap artefacts.
- Frame of 627 lines -> frame_done pulse; v_total=627; good_cnt clears; locked=0.
- rst asserted mid-frame for 1 cycle -> all outputs 0 next cycle; no pix_valid until a vs edge is seen; relock after LOCK_FRAMES+1 vs edges.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers line/frame timing from hs/vs/rgb,
// regenerates pixel coordinates, tracks lock and a per-frame checksum.
module vga_sync_decoder #(
  parameter int   H_TOTAL       = 1056,
  parameter int   V_TOTAL       = 628,
  parameter int   H_ACTIVE      = 800,
  parameter int   V_ACTIVE      = 600,
  parameter int   H_SYNC_TO_ACT = 216,
  parameter int   V_SYNC_TO_ACT = 27,
  parameter logic HS_POL        = 1'b1,
  parameter logic VS_POL        = 1'b1,
  parameter int   LOCK_FRAMES   = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        hs,
  input  logic        vs,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic        pix_valid,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [11:0] pix,
  output logic [10:0] h_total,
  output logic [10:0] v_total,
  output logic        locked,
  output logic        frame_done,
  output logic [15:0] frame_sum,
  output logic        sync_err
);

  localparam logic [10:0] CMAX = 11'h7FF;
  localparam logic [11:0] HTOT = 12'(H_TOTAL);
  localparam logic [10:0] VTOT = 11'(V_TOTAL);
  localparam logic [10:0] HS0  = 11'(H_SYNC_TO_ACT);
  localparam logic [10:0] HS1  = 11'(H_SYNC_TO_ACT + H_ACTIVE);
  localparam logic [10:0] VS0  = 11'(V_SYNC_TO_ACT);
  localparam logic [10:0] VS1  = 11'(V_SYNC_TO_ACT + V_ACTIVE);
  localparam logic [7:0]  LOCKN = 8'(LOCK_FRAMES);

  // input stage
  logic        hs_q, hs_q2;
  logic        vs_q, vs_q2;
  logic [11:0] rgb_q;

  // timing state
  logic [10:0] hcnt_q, hcnt_d;
  logic [10:0] lcnt_q, lcnt_d;
  logic        vs_pend_q, vs_pend_d;
  logic [11:0] rgb_q2;

  // frame state
  logic        frame_bad_q, frame_bad_d;
  logic        frame_seen_q, frame_seen_d;
  logic [7:0]  good_cnt_q, good_cnt_d;
  logic [15:0] acc_q, acc_d;

  // registered outputs
  logic        pix_valid_q, pix_valid_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic [11:0] pix_q, pix_d;
  logic [10:0] h_total_q, h_total_d;
  logic [10:0] v_total_q, v_total_d;
  logic        locked_q, locked_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_sum_q, frame_sum_d;
  logic        sync_err_q, sync_err_d;

  // combinational helpers
  logic        hs_edge, vs_edge;
  logic        hcnt_sat;
  logic [11:0] line_len;
  logic        bad_line;
  logic        take_vs;
  logic [10:0] frame_len;
  logic        bad_now;
  logic        good_frame;
  logic        judge;
  logic [15:0] acc_plus;
  logic        in_win;

  assign pix_valid  = pix_valid_q;
  assign x          = x_q;
  assign y          = y_q;
  assign pix        = pix_q;
  assign h_total    = h_total_q;
  assign v_total    = v_total_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign frame_sum  = frame_sum_q;
  assign sync_err   = sync_err_q;

  // line counter, line-length check and vs-aligned line counter
  always_comb begin
    hs_edge  = (hs_q == HS_POL) && (hs_q2 != HS_POL);
    vs_edge  = (vs_q == VS_POL) && (vs_q2 != VS_POL);
    hcnt_sat = (hcnt_q == CMAX);
    line_len = {1'b0, hcnt_q} + 12'd1;
    bad_line = hs_edge && (hcnt_sat || (line_len != HTOT));

    hcnt_d = hcnt_q;
    if (hs_edge) begin
      hcnt_d = '0;
    end else if (!hcnt_sat) begin
      hcnt_d = hcnt_q + 11'd1;
    end

    h_total_d = h_total_q;
    if (hs_edge) begin
      h_total_d = hcnt_sat ? CMAX : line_len[10:0];
    end

    take_vs   = vs_pend_q || vs_edge;
    lcnt_d    = lcnt_q;
    vs_pend_d = vs_pend_q;
    if (hs_edge) begin
      vs_pend_d = 1'b0;
      if (take_vs) begin
        lcnt_d = '0;
      end else if (lcnt_q != CMAX) begin
        lcnt_d = lcnt_q + 11'd1;
      end
    end else if (vs_edge) begin
      vs_pend_d = 1'b1;
    end
  end

  // frame judgement, lock tracking and checksum
  always_comb begin
    frame_len  = (lcnt_q == CMAX) ? CMAX : lcnt_q + 11'd1;
    bad_now    = frame_bad_q || bad_line;
    good_frame = (frame_len == VTOT) && !bad_now;
    judge      = vs_edge && frame_seen_q;

    good_cnt_d = good_cnt_q;
    if (judge) begin
      if (!good_frame) begin
        good_cnt_d = '0;
      end else if (good_cnt_q != 8'hFF) begin
        good_cnt_d = good_cnt_q + 8'd1;
      end
    end

    locked_d = locked_q;
    if (bad_line) begin
      locked_d = 1'b0;
    end
    if (judge) begin
      locked_d = (good_cnt_d >= LOCKN);
    end

    sync_err_d   = bad_line && locked_q;
    frame_bad_d  = vs_edge ? 1'b0 : bad_now;
    frame_seen_d = frame_seen_q || vs_edge;
    frame_done_d = vs_edge;
    v_total_d    = vs_edge ? frame_len : v_total_q;

    acc_plus = acc_q;
    if (pix_valid_q) begin
      acc_plus = acc_q + {4'b0, pix_q};
    end
    acc_d       = vs_edge ? 16'd0 : acc_plus;
    frame_sum_d = vs_edge ? acc_plus : frame_sum_q;
  end

  // active-window decode for the pixel output stage
  always_comb begin
    in_win = frame_seen_q
          && (hcnt_q >= HS0) && (hcnt_q < HS1)
          && (lcnt_q >= VS0) && (lcnt_q < VS1);
    pix_valid_d = in_win;
    x_d   = in_win ? hcnt_q - HS0 : 11'd0;
    y_d   = in_win ? lcnt_q - VS0 : 11'd0;
    pix_d = in_win ? rgb_q2 : 12'd0;
  end

  // stage 1: sample sync and colour, keep previous sync level
  always_ff @(posedge pclk) begin
    if (rst) begin
      hs_q  <= 1'b0;
      hs_q2 <= 1'b0;
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs;
      hs_q2 <= hs_q;
      vs_q  <= vs;
      vs_q2 <= vs_q;
      rgb_q <= {r, g, b};
    end
  end

  // stage 2: pixel/line counters aligned with the delayed colour
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcnt_q    <= '0;
      lcnt_q    <= '0;
      vs_pend_q <= 1'b0;
      rgb_q2    <= '0;
      h_total_q <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      lcnt_q    <= lcnt_d;
      vs_pend_q <= vs_pend_d;
      rgb_q2    <= rgb_q;
      h_total_q <= h_total_d;
    end
  end

  // frame bookkeeping: lock, error pulse, height and checksum
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_bad_q  <= 1'b0;
      frame_seen_q <= 1'b0;
      good_cnt_q   <= '0;
      acc_q        <= '0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      v_total_q    <= '0;
      frame_sum_q  <= '0;
    end else begin
      frame_bad_q  <= frame_bad_d;
      frame_seen_q <= frame_seen_d;
      good_cnt_q   <= good_cnt_d;
      acc_q        <= acc_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
      frame_done_q <= frame_done_d;
      v_total_q    <= v_total_d;
      frame_sum_q  <= frame_sum_d;
    end
  end

  // stage 3: registered pixel outputs
  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      pix_q       <= '0;
    end else begin
      pix_valid_q <= pix_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed frame table plus hand sequences
// for short lines, hs dropout and mid-frame reset, on a tiny mode.
module tb_vga_sync_decoder;

  localparam int HT   = 24;
  localparam int HA   = 12;
  localparam int HS2A = 6;
  localparam int HSW  = 3;
  localparam int VT   = 10;
  localparam int VA   = 5;
  localparam int VS2A = 3;
  localparam int VSW  = 2;

  logic        pclk = 1'b0;
  logic        rst;
  logic        hs, vs;
  logic [3:0]  r, g, b;
  logic        pix_valid;
  logic [10:0] x, y;
  logic [11:0] pix;
  logic [10:0] h_total, v_total;
  logic        locked, frame_done;
  logic [15:0] frame_sum;
  logic        sync_err;

  int n_chk = 0;
  int n_err = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT),
    .H_ACTIVE(HA), .V_ACTIVE(VA),
    .H_SYNC_TO_ACT(HS2A), .V_SYNC_TO_ACT(VS2A),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .LOCK_FRAMES(2)
  ) dut (
    .pclk(pclk), .rst(rst),
    .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b),
    .pix_valid(pix_valid),
    .x(x), .y(y), .pix(pix),
    .h_total(h_total), .v_total(v_total),
    .locked(locked), .frame_done(frame_done),
    .frame_sum(frame_sum), .sync_err(sync_err)
  );

  always #5 pclk = ~pclk;

  // monitor: running totals and snapshots at event pulses
  int          pv_total = 0;
  int          pv_last = 0;
  int          snap_npix = 0;
  int          fd_total = 0;
  int          serr_total = 0;
  int          wh_total = 0;
  logic [10:0] wh_x = '0, wh_y = '0;
  logic [11:0] wh_pix = '0;
  logic [10:0] snap_vt = '0, snap_ht = '0, serr_ht = '0;
  logic [15:0] snap_sum = '0;
  logic        snap_lock = 1'b0, serr_lock = 1'b0;

  always @(negedge pclk) begin
    if (pix_valid) pv_total <= pv_total + 1;
    if (pix_valid && pix == 12'hFFF) begin
      wh_total <= wh_total + 1;
      wh_x     <= x;
      wh_y     <= y;
      wh_pix   <= pix;
    end
    if (frame_done) begin
      fd_total  <= fd_total + 1;
      snap_vt   <= v_total;
      snap_ht   <= h_total;
      snap_sum  <= frame_sum;
      snap_lock <= locked;
      snap_npix <= pv_total - pv_last;
      pv_last   <= pv_total;
    end
    if (sync_err) begin
      serr_total <= serr_total + 1;
      serr_ht    <= h_total;
      serr_lock  <= locked;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] px_of(int ln, int c,
      logic [11:0] fill, int wx, int wy);
    if (c >= HS2A && c < HS2A + HA && ln >= VS2A && ln < VS2A + VA) begin
      if (c - HS2A == wx && ln - VS2A == wy) return 12'hFFF;
      return fill;
    end
    return 12'h000;
  endfunction

  task automatic put(int ln, int c, logic [11:0] fill, int wx, int wy);
    hs = (c < HSW);
    vs = (ln < VSW);
    {r, g, b} = px_of(ln, c, fill, wx, wy);
  endtask

  task automatic drive_cols(int ln, int c0, int c1,
                            logic [11:0] fill, int wx, int wy);
    for (int c = c0; c < c1; c++) begin
      @(negedge pclk);
      put(ln, c, fill, wx, wy);
    end
  endtask

  task automatic drive_lines(int l0, int l1, logic [11:0] fill,
                             int wx, int wy, int sline, int slen);
    for (int ln = l0; ln < l1; ln++) begin
      drive_cols(ln, 0, (ln == sline) ? slen : HT, fill, wx, wy);
    end
  endtask

  typedef struct {
    int          lines;
    int          sline;
    int          slen;
    logic [11:0] fill;
    int          wx;
    int          wy;
    int          e_vt;
    int          e_ht;
    logic        e_lock;
    logic [15:0] e_sum;
    int          e_npix;
    int          e_serr;
  } rec_t;

  rec_t tbl [9];

  int s0, w0, f0, p0;

  initial begin
    // per frame: stimulus, then what the vs edge ending it must report
    tbl[0] = '{10, -1,  0, 12'h888, -1, -1, 10, 24, 1'b0, 16'hFFE0, 60, 0};
    tbl[1] = '{10, -1,  0, 12'h888, -1, -1, 10, 24, 1'b1, 16'hFFE0, 60, 0};
    tbl[2] = '{10, -1,  0, 12'h000,  5,  2, 10, 24, 1'b1, 16'h0FFF, 60, 0};
    tbl[3] = '{10,  4, 23, 12'h123, -1, -1, 10, 24, 1'b0, 16'h4434, 60, 1};
    tbl[4] = '{10, -1,  0, 12'h888, -1, -1, 10, 24, 1'b0, 16'hFFE0, 60, 0};
    tbl[5] = '{10, -1,  0, 12'h888, -1, -1, 10, 24, 1'b1, 16'hFFE0, 60, 0};
    tbl[6] = '{ 9, -1,  0, 12'h001, -1, -1,  9, 24, 1'b0, 16'h003C, 60, 0};
    tbl[7] = '{10, -1,  0, 12'h888, -1, -1, 10, 24, 1'b0, 16'hFFE0, 60, 0};
    tbl[8] = '{10, -1,  0, 12'h0F0, -1, -1, 10, 24, 1'b1, 16'h3840, 60, 0};

    rst = 1'b1;
    hs = 1'b0; vs = 1'b0;
    r = '0; g = '0; b = '0;
    repeat (3) @(negedge pclk);
    chk("reset_pix", {pix_valid, x, y, pix, locked, frame_done, sync_err}, '0);
    chk("reset_meas", {h_total, v_total, frame_sum}, '0);
    rst = 1'b0;
    repeat (4) @(negedge pclk);

    for (int i = 0; i <= 9; i++) begin
      s0 = serr_total;
      w0 = wh_total;
      f0 = fd_total;
      if (i < 9) begin
        drive_lines(0, tbl[i].lines, tbl[i].fill, tbl[i].wx,
                    tbl[i].wy, tbl[i].sline, tbl[i].slen);
      end else begin
        drive_lines(0, VT, 12'h888, -1, -1, -1, 0);
      end
      if (i > 0) begin
        chk($sformatf("f%0d_done", i - 1), fd_total - f0, 1);
        chk($sformatf("f%0d_vtotal", i - 1), snap_vt, tbl[i-1].e_vt);
        chk($sformatf("f%0d_htotal", i - 1), snap_ht, tbl[i-1].e_ht);
        chk($sformatf("f%0d_locked", i - 1), snap_lock, tbl[i-1].e_lock);
        chk($sformatf("f%0d_sum", i - 1), snap_sum, tbl[i-1].e_sum);
        chk($sformatf("f%0d_npix", i - 1), snap_npix, tbl[i-1].e_npix);
      end
      if (i < 9) begin
        chk($sformatf("f%0d_serr", i), serr_total - s0, tbl[i].e_serr);
        if (tbl[i].wx >= 0) begin
          chk("white_cnt", wh_total - w0, 1);
          chk("white_x", wh_x, tbl[i].wx);
          chk("white_y", wh_y, tbl[i].wy);
          chk("white_pix", wh_pix, 12'hFFF);
        end
      end
    end
    chk("short_htotal", serr_ht, 23);
    chk("short_lock_drop", serr_lock, 1'b0);

    // hs dropout: counter must saturate, not wrap into a new line
    drive_lines(0, 5, 12'h888, -1, -1, -1, 0);
    chk("sat_pre_lock", locked, 1'b1);
    p0 = pv_total;
    s0 = serr_total;
    for (int c = 0; c < 3003; c++) begin
      @(negedge pclk);
      hs = (c < HSW);
      vs = 1'b0;
      {r, g, b} = 12'h888;
    end
    chk("sat_pix", pv_total - p0, 12);
    chk("sat_lock_hold", locked, 1'b1);
    chk("sat_no_serr", serr_total - s0, 0);
    drive_lines(6, 7, 12'h888, -1, -1, -1, 0);
    chk("sat_serr", serr_total - s0, 1);
    chk("sat_lock_drop", locked, 1'b0);
    drive_lines(7, VT, 12'h888, -1, -1, -1, 0);

    // one-cycle reset in the middle of an active line
    drive_lines(0, 4, 12'h888, -1, -1, -1, 0);
    drive_cols(4, 0, 9, 12'h888, -1, -1);
    rst = 1'b1;
    @(negedge pclk);
    chk("mid_rst_pix", {pix_valid, x, y, pix, locked, frame_done, sync_err}, '0);
    chk("mid_rst_meas", {h_total, v_total, frame_sum}, '0);
    rst = 1'b0;
    p0 = pv_total;
    put(4, 9, 12'h888, -1, -1);
    drive_cols(4, 10, HT, 12'h888, -1, -1);
    drive_lines(5, VT, 12'h888, -1, -1, -1, 0);
    chk("mid_rst_no_pix", pv_total - p0, 0);
    drive_lines(0, VT, 12'h888, -1, -1, -1, 0);
    chk("relock_vs1", locked, 1'b0);
    drive_lines(0, VT, 12'h888, -1, -1, -1, 0);
    chk("relock_vs2", locked, 1'b0);
    drive_lines(0, 1, 12'h888, -1, -1, -1, 0);
    chk("relock_vs3", locked, 1'b1);
    drive_lines(1, VT, 12'h888, -1, -1, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
